id_ex_stage: RTL
================

# id_ex_stage

- Decode-to-execute pipeline stage of the RISC-V core.
- Registers one decoded instruction and presents the ALU operand inputs and control: A, B, ctl, shamt.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Uses a valid/ready handshake with stall and flush.

## Interface
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_W, 5, register index width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  stage can accept this cycle
- id_rs1_data_i, id_rs2_data_i  in  DATA_WIDTH  register-file read data
- id_imm_i  in  DATA_WIDTH  sign-extended immediate
- id_use_imm_i  in  1  B operand = immediate
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  REG_ADDR_W  source/destination indices
- id_rd_we_i  in  1  instruction writes rd
- id_alu_ctl_i  in  4  alu_pkg ALU operation code
- flush_i  in  1  kill the held instruction and any incoming one
- exm_rd_addr_i, mwb_rd_addr_i  in  REG_ADDR_W  destination index in EX/MEM, MEM/WB
- exm_rd_we_i, mwb_rd_we_i  in  1  write enable in EX/MEM, MEM/WB
- exm_result_i, mwb_result_i  in  DATA_WIDTH  result in EX/MEM, MEM/WB
- ex_valid_o  out  1  outputs hold a valid instruction
- ex_ready_i  in  1  execute consumes this cycle
- alu_a_o, alu_b_o  out  DATA_WIDTH  ALU operands
- alu_ctl_o  out  4  ALU operation
- alu_shamt_o  out  5  equals alu_b_o[4:0]
- ex_rd_addr_o  out  REG_ADDR_W  destination index
- ex_rd_we_o  out  1  destination write enable (gated by ex_valid_o)
- stall_cnt_o  out  16  saturating count of back-pressure cycles

## Operation
- One-entry slot: valid bit plus stored rs1/rs2 data, rs addresses, imm, use_imm, rd, rd_we, ctl.
- id_ready_o = !ex_valid_o || ex_ready_i (combinational).
- Accept occurs when id_valid_i && id_ready_o && !flush_i: load the slot and set valid.
- Retire occurs when ex_valid_o && ex_ready_i and there is no accept: clear valid.
- Flush: clear valid next edge. Flush has priority over accept and hold; an incoming instruction in the flush cycle is dropped.
- Forwarding (per source operand):
  - If exm_rd_we_i, exm_rd_addr_i == rs, and rs != 0: use exm_result_i.
  - Otherwise, same test on MEM/WB: use mwb_result_i.
  - Otherwise: use stored data.
  - EX/MEM has priority over MEM/WB; x0 is never forwarded.
- Sticky update: while valid and not retiring, a forwarded value is written back into the stored operand. A hold therefore survives producers leaving the pipeline.
- alu_a_o = forwarded rs1. alu_b_o = imm if use_imm, else forwarded rs2.
- ex_rd_we_o = stored rd_we && ex_valid_o.
- stall_cnt_o increments on each cycle with ex_valid_o && !ex_ready_i and saturates at 16'hFFFF.

## Timing
- Reset values:
  - ex_valid_o = 0; id_ready_o = 1.
  - alu_a_o, alu_b_o, alu_shamt_o = 0; alu_ctl_o = ALU_ADD; ex_rd_addr_o = 0; ex_rd_we_o = 0; stall_cnt_o = 0.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N.
- Forwarding muxes are combinational: forwarding inputs affect alu_a_o/alu_b_o in the same cycle.
- Full throughput: with ex_ready_i held high, one instruction per cycle.
- Simultaneous retire and accept: the slot is reloaded and valid stays 1.
- Reset asserted mid-operation: valid and counter clear immediately (asynchronous), and the in-flight instruction is lost.

## Configuration
- FORWARDING_EN defined:
  - Forwarding muxes and sticky update are compiled in.
  - Without it, alu_a_o/alu_b_o come only from stored data, forwarding inputs are unused, and decode must stall on hazards.

## Structure
- alu_pkg: ALU operation codes (existing).
- New pipe_pkg:
  - fwd_sel_t enum: FWD_NONE, FWD_EXM, FWD_MWB.
  - id_ex_t packed struct for slot contents.
- Sub-module fwd_mux: one operand's source compare, priority select, and fwd_sel_t output; instantiated twice.

## Test plan
- Reset, then id_valid_i=1, rs1=5 data 0x10, rs2=6 data 0x20, ALU_ADD, ex_ready_i=1 -> next cycle ex_valid_o=1, alu_a_o=0x10, alu_b_o=0x20.
- Held instruction rs1=3, exm_rd_addr_i=3 we=1 result 0xAA, mwb_rd_addr_i=3 we=1 result 0xBB -> alu_a_o=0xAA. Same setup with rs1=0 -> stored data, no forward.
- ex_ready_i=0 for 4 cycles while valid, exm forwards 0x55 in cycle 1 only -> alu_a_o stays 0x55, id_ready_o=0, stall_cnt_o=4.
- use_imm=1, imm=0x7, rs2 forwarding hit -> alu_b_o=0x7, alu_shamt_o=7.
- flush_i with id_valid_i=1 while valid -> ex_valid_o=0 next cycle, incoming instruction dropped.
- rst_ni low mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   ALU operation codes shared by the decode, execute and pipeline stages.
//   Encodings are fixed at 4 bits; ALU_ADD is the all-zero code, so a
//   cleared pipeline slot reads as an ADD.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared pipeline types: the forwarding-source select and the ID/EX slot
//   contents. PIPE_DATA_W / PIPE_ADDR_W size the slot struct and must match
//   the DATA_WIDTH / REG_ADDR_W parameters of the stages that use it.
package pipe_pkg;

  import alu_pkg::*;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;

  // Which pipeline register feeds an operand this cycle.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_MWB  = 2'd2
  } fwd_sel_t;

  // Everything the ID/EX slot remembers about one decoded instruction.
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] rs1_data;
    logic [PIPE_DATA_W-1:0] rs2_data;
    logic [PIPE_DATA_W-1:0] imm;
    logic [PIPE_ADDR_W-1:0] rs1_addr;
    logic [PIPE_ADDR_W-1:0] rs2_addr;
    logic [PIPE_ADDR_W-1:0] rd_addr;
    logic                   use_imm;
    logic                   rd_we;
    alu_op_t                ctl;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
//   Forwarding select for one source operand. Compares the operand's
//   register index against the EX/MEM and MEM/WB destinations and picks the
//   youngest matching producer; x0 is never forwarded.
// Ports:
//   rs_addr, stored_data          - operand index and the value held in ID/EX
//   exm_rd_we/addr, exm_result    - EX/MEM producer
//   mwb_rd_we/addr, mwb_result    - MEM/WB producer
//   fwd_data                      - selected operand value
//   fwd_sel                       - which source was selected
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0] stored_data,
  input  logic                  exm_rd_we,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  mwb_rd_we,
  input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
  input  logic [DATA_WIDTH-1:0] mwb_result,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output fwd_sel_t              fwd_sel
);

  logic rs_nonzero;
  logic exm_hit;
  logic mwb_hit;

  assign rs_nonzero = (rs_addr != '0);
  assign exm_hit    = exm_rd_we && (exm_rd_addr == rs_addr) && rs_nonzero;
  assign mwb_hit    = mwb_rd_we && (mwb_rd_addr == rs_addr) && rs_nonzero;

  // EX/MEM is the younger producer, so it wins when both stages match.
  always_comb begin
    fwd_sel  = FWD_NONE;
    fwd_data = stored_data;
    if (exm_hit) begin
      fwd_sel  = FWD_EXM;
      fwd_data = exm_result;
    end else if (mwb_hit) begin
      fwd_sel  = FWD_MWB;
      fwd_data = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode-to-execute pipeline register. Holds one decoded instruction in a
//   single-entry slot with a valid/ready handshake, stall and flush, and
//   presents ALU operands and control to execute.
//   Optional feature macro: FORWARDING_EN. When defined, RAW hazards are
//   resolved by forwarding from EX/MEM and MEM/WB, and a stalled slot
//   captures forwarded values so they survive the producer retiring. When
//   undefined, operands come only from the slot and decode must stall on
//   hazards; the forwarding inputs are then ignored.
// Ports:
//   clk_i, rst_ni                        - clock, async active-low reset
//   id_valid_i / id_ready_o              - handshake from decode
//   id_rs1/rs2_data_i, id_imm_i, ...     - decoded instruction fields
//   flush_i                              - kill held and incoming instruction
//   exm_* / mwb_*                        - forwarding sources
//   ex_valid_o / ex_ready_i              - handshake to execute
//   alu_a_o, alu_b_o, alu_ctl_o, alu_shamt_o - ALU inputs
//   ex_rd_addr_o, ex_rd_we_o             - destination of held instruction
//   stall_cnt_o                          - saturating back-pressure counter
module id_ex_stage
  import alu_pkg::*;
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic                  id_use_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_rd_we_i,
  input  logic [3:0]            id_alu_ctl_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] mwb_rd_addr_i,
  input  logic                  exm_rd_we_i,
  input  logic                  mwb_rd_we_i,
  input  logic [DATA_WIDTH-1:0] exm_result_i,
  input  logic [DATA_WIDTH-1:0] mwb_result_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [3:0]            alu_ctl_o,
  output logic [4:0]            alu_shamt_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_rd_we_o,
  output logic [15:0]           stall_cnt_o
);

  id_ex_t                slot;
  id_ex_t                incoming;
  logic                  ex_valid;
  logic [15:0]           stall_cnt;
  logic                  accept;
  logic                  retire;
  logic [DATA_WIDTH-1:0] rs1_fwd;
  logic [DATA_WIDTH-1:0] rs2_fwd;

  assign id_ready_o = !ex_valid || ex_ready_i;
  assign accept     = id_valid_i && id_ready_o && !flush_i;
  assign retire     = ex_valid && ex_ready_i;

  // Pack the decode-side fields into the slot layout.
  always_comb begin
    incoming          = '0;
    incoming.rs1_data = id_rs1_data_i;
    incoming.rs2_data = id_rs2_data_i;
    incoming.imm      = id_imm_i;
    incoming.rs1_addr = id_rs1_addr_i;
    incoming.rs2_addr = id_rs2_addr_i;
    incoming.rd_addr  = id_rd_addr_i;
    incoming.use_imm  = id_use_imm_i;
    incoming.rd_we    = id_rd_we_i;
    incoming.ctl      = alu_op_t'(id_alu_ctl_i);
  end

`ifdef FORWARDING_EN
  fwd_sel_t rs1_sel;
  fwd_sel_t rs2_sel;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr     (slot.rs1_addr),
    .stored_data (slot.rs1_data),
    .exm_rd_we   (exm_rd_we_i),
    .exm_rd_addr (exm_rd_addr_i),
    .exm_result  (exm_result_i),
    .mwb_rd_we   (mwb_rd_we_i),
    .mwb_rd_addr (mwb_rd_addr_i),
    .mwb_result  (mwb_result_i),
    .fwd_data    (rs1_fwd),
    .fwd_sel     (rs1_sel)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr     (slot.rs2_addr),
    .stored_data (slot.rs2_data),
    .exm_rd_we   (exm_rd_we_i),
    .exm_rd_addr (exm_rd_addr_i),
    .exm_result  (exm_result_i),
    .mwb_rd_we   (mwb_rd_we_i),
    .mwb_rd_addr (mwb_rd_addr_i),
    .mwb_result  (mwb_result_i),
    .fwd_data    (rs2_fwd),
    .fwd_sel     (rs2_sel)
  );
`else
  logic unused_fwd_inputs;

  assign rs1_fwd = slot.rs1_data;
  assign rs2_fwd = slot.rs2_data;
  assign unused_fwd_inputs = ^{exm_rd_addr_i, exm_rd_we_i, exm_result_i,
                               mwb_rd_addr_i, mwb_rd_we_i, mwb_result_i,
                               slot.rs1_addr, slot.rs2_addr};
`endif

  // Slot control: flush beats accept beats retire. While an instruction is
  // held under back-pressure, any forwarded operand is written back into the
  // slot so the value is kept after its producer leaves the pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid <= 1'b0;
      slot     <= '0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      slot     <= incoming;
    end else if (retire) begin
      ex_valid <= 1'b0;
`ifdef FORWARDING_EN
    end else if (ex_valid) begin
      if (rs1_sel != FWD_NONE) slot.rs1_data <= rs1_fwd;
      if (rs2_sel != FWD_NONE) slot.rs2_data <= rs2_fwd;
`endif
    end
  end

  // Count cycles where execute refuses a valid instruction; stick at max.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready_i && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign ex_valid_o   = ex_valid;
  assign alu_a_o      = rs1_fwd;
  assign alu_b_o      = slot.use_imm ? slot.imm : rs2_fwd;
  assign alu_shamt_o  = alu_b_o[4:0];
  assign alu_ctl_o    = slot.ctl;
  assign ex_rd_addr_o = slot.rd_addr;
  assign ex_rd_we_o   = slot.rd_we && ex_valid;
  assign stall_cnt_o  = stall_cnt;

endmodule
